gray_ptr_rx: RTL and testbench
==============================

Name: gray_ptr_rx

Overview:
Receive-side companion to the team's Gray-code pointer counter, in the async FIFO's opposite clock domain.
- Takes a Gray-coded pointer launched from a foreign clock domain and resynchronizes it through a SYNC_STAGES flop chain.
- Decodes it to binary and reports the per-cycle advance (delta).
- Flags any illegal multi-bit Gray transition.
- Feeds full/empty and occupancy logic in the local domain.

Parameters:
WIDTH, 8, pointer width in bits (>=2).
SYNC_STAGES, 2, synchronizer depth (>=2; elaboration error if <2).

Ports:
clk  in  1  local-domain clock.
rstn  in  1  reset, asynchronous, active-low.
gray_in  in  WIDTH  Gray pointer from the foreign domain; asynchronous to clk.
err_clr  in  1  synchronous clear of the sticky error flag.
gray_sync  out  WIDTH  output of the last synchronizer stage.
bin  out  WIDTH  registered binary decode of the synchronized pointer.
delta  out  WIDTH  (new bin - previous bin) mod 2^WIDTH, registered.
step  out  1  one-cycle pulse: synchronized pointer changed this update.
err  out  1  sticky flag: illegal Gray transition seen.

Behaviour:
- Reset (rstn low, asynchronous):
  - All synchronizer stages, gray_sync, bin, delta, step and err go to 0.
  - The internal previous-Gray register (gray_d) also goes to 0.
  - Release is synchronous to clk in use; the first update occurs on the first clk edge after release.
- Synchronizer:
  - sync[0] <= gray_in; sync[i] <= sync[i-1]; gray_sync = sync[SYNC_STAGES-1].
  - No logic between stages.
  - gray_in is never used combinationally.
- Decode (combinational on gray_sync): b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
- Update stage, every clk edge:
  - bin <= g2b(gray_sync)
  - gray_d <= gray_sync
  - delta <= g2b(gray_sync) - bin, truncated to WIDTH. Wrap is natural: 15 -> 0 gives delta = 1 for WIDTH = 4.
  - step <= (gray_sync != gray_d)
  - err set when popcount(gray_sync ^ gray_d) > 1.
- Latency:
  - A gray_in value stable across SYNC_STAGES+1 rising edges appears on gray_sync after edge SYNC_STAGES.
  - It appears on bin/delta/step/err after edge SYNC_STAGES+1.
- Stable input: delta = 0 and step = 0 every cycle after the pipeline settles; bin holds its value.
- err handling:
  - err is sticky; err_clr = 1 clears it on the next edge.
  - If set and clear occur on the same edge, set wins and err = 1.
  - delta and bin are still updated on an illegal transition; there is no suppression.
- First update after reset compares against gray_d = 0. A nonzero gray_in held through reset therefore yields step = 1 and delta = decoded value. If that value is multi-bit Gray, err = 1.
- Reset mid-operation: all outputs drop to 0 immediately (asynchronously). Any in-flight synchronizer contents are discarded.
- No enable input; the block updates every cycle.

Test Plan:
1. WIDTH=4, SYNC_STAGES=2. Assert rstn low with gray_in=0110 -> all outputs 0 during reset. Release with gray_in=0 -> outputs remain 0, step never pulses, err=0.
2. Walk gray_in through Gray(0..15) then Gray(0), each held 4 cycles.
   - -> bin follows 0..15,0.
   - -> delta=1 and step=1 for exactly one cycle per change, including the 15 -> 0 wrap (gray 1000 -> 0000).
   - -> err stays 0.
3. Latency: change gray_in 0000 -> 0001 just before edge N -> gray_sync=0001 after edge N+1; bin=1, step=1 after edge N+2. Repeat with SYNC_STAGES=3 -> one cycle later each.
4. Illegal jump: gray_in 0000 -> 0011 -> err=1, delta=2, bin=2, step=1. Hold err_clr=0 for 10 cycles -> err stays 1. Pulse err_clr for one cycle -> err=0 on the next edge.
5. Illegal jump 0011 -> 0101 arriving on the same edge as err_clr=1 -> err=1 (set wins), delta=4, bin=6.
6. Mid-count reset: at bin=9, drop rstn for 1 cycle with gray_in=Gray(9)=1101 -> outputs 0 asynchronously. After release: step=1, delta=9, bin=9 after SYNC_STAGES+1 edges. err=1, because 0000 -> 1101 is a 3-bit change.

Source files
------------

// File: rtl/gray_ptr_rx_if.sv
// Signal bundle between a Gray-pointer source and the receive-side resynchronizer.
// The master drives the foreign-domain pointer and error clear; the slave returns decoded status.
interface gray_ptr_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] gray_in;
    logic             err_clr;
    logic [WIDTH-1:0] gray_sync;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] delta;
    logic             step;
    logic             err;

    modport master (
        output gray_in, err_clr,
        input  gray_sync, bin, delta, step, err
    );

    modport slave (
        input  gray_in, err_clr,
        output gray_sync, bin, delta, step, err
    );
endinterface

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray-coded FIFO pointer: resynchronizes into clk, decodes to binary,
// reports per-cycle advance and flags any multi-bit Gray transition as a sticky error.
module gray_ptr_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    gray_ptr_rx_if.slave bus
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("gray_ptr_rx: SYNC_STAGES must be at least 2");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("gray_ptr_rx: WIDTH must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
    logic [WIDTH-1:0]                  gs;
    logic [WIDTH-1:0]                  gray_d;
    logic [WIDTH-1:0]                  bin_nxt;
    logic [WIDTH-1:0]                  diff;
    logic                              multi;

    logic [WIDTH-1:0]                  bin_q;
    logic [WIDTH-1:0]                  delta_q;
    logic                              step_q;
    logic                              err_q;

    // Plain flop chain: gray_in only ever reaches a flop D input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.gray_in};
        end
    end

    assign gs = sync[SYNC_STAGES-1];

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        bin_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_nxt[i] = ^(gs >> i);
        end
    end

    // More than one bit flipped iff clearing the lowest set bit leaves something set.
    assign diff  = gs ^ gray_d;
    assign multi = |(diff & (diff - WIDTH'(1)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gray_d  <= '0;
            bin_q   <= '0;
            delta_q <= '0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            gray_d  <= gs;
            bin_q   <= bin_nxt;
            delta_q <= bin_nxt - bin_q;
            step_q  <= |diff;
            if (multi) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.gray_sync = gs;
    assign bus.bin       = bin_q;
    assign bus.delta     = delta_q;
    assign bus.step      = step_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Bench for gray_ptr_rx: two instances (2 and 3 sync stages) share one stimulus stream;
// expected outputs are queued at drive time and popped after every clock edge.
module tb_gray_ptr_rx;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] bin;
        logic [W-1:0] delta;
        logic         step;
        logic         ill;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] gray_in;
    logic         err_clr;

    always #5 clk = ~clk;

    gray_ptr_rx_if #(.WIDTH(W)) if2 ();
    gray_ptr_rx_if #(.WIDTH(W)) if3 ();

    assign if2.gray_in = gray_in;
    assign if2.err_clr = err_clr;
    assign if3.gray_in = gray_in;
    assign if3.err_clr = err_clr;

    gray_ptr_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut2 (.clk(clk), .rstn(rstn), .bus(if2.slave));
    gray_ptr_rx #(.WIDTH(W), .SYNC_STAGES(3)) dut3 (.clk(clk), .rstn(rstn), .bus(if3.slave));

    exp_t         q2[$];
    exp_t         q3[$];
    logic [W-1:0] gq2[$];
    logic [W-1:0] gq3[$];
    logic [W-1:0] m_gray;
    logic [W-1:0] m_bin;
    logic         e2;
    logic         e3;
    int           n_chk = 0;
    int           n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic model_reset();
        exp_t z;
        z = '0;
        q2.delete(); q3.delete(); gq2.delete(); gq3.delete();
        repeat (2) q2.push_back(z);
        repeat (3) q3.push_back(z);
        gq2.push_back('0);
        repeat (2) gq3.push_back('0);
        m_gray = '0;
        m_bin  = '0;
        e2     = 1'b0;
        e3     = 1'b0;
    endtask

    task automatic push_stim();
        exp_t e;
        e.bin   = g2b(gray_in);
        e.delta = e.bin - m_bin;
        e.step  = (gray_in != m_gray);
        e.ill   = ($countones(gray_in ^ m_gray) > 1);
        q2.push_back(e);
        q3.push_back(e);
        gq2.push_back(gray_in);
        gq3.push_back(gray_in);
        m_gray = gray_in;
        m_bin  = e.bin;
    endtask

    task automatic cmp_outs(input string nm, input logic [W-1:0] gs, input logic [W-1:0] b,
                            input logic [W-1:0] d, input logic st, input logic er,
                            input logic [W-1:0] xgs, input exp_t x, input logic xer);
        check_val({nm, ".gray_sync"}, 32'(gs), 32'(xgs));
        check_val({nm, ".bin"},       32'(b),  32'(x.bin));
        check_val({nm, ".delta"},     32'(d),  32'(x.delta));
        check_val({nm, ".step"},      32'(st), 32'(x.step));
        check_val({nm, ".err"},       32'(er), 32'(xer));
    endtask

    task automatic tick();
        exp_t  x;
        logic  clr;
        logic [W-1:0] g;
        clr = err_clr;
        push_stim();
        @(posedge clk);
        #1;
        x = q2.pop_front();
        g = gq2.pop_front();
        e2 = x.ill ? 1'b1 : (clr ? 1'b0 : e2);
        cmp_outs("s2", if2.gray_sync, if2.bin, if2.delta, if2.step, if2.err, g, x, e2);
        x = q3.pop_front();
        g = gq3.pop_front();
        e3 = x.ill ? 1'b1 : (clr ? 1'b0 : e3);
        cmp_outs("s3", if3.gray_sync, if3.bin, if3.delta, if3.step, if3.err, g, x, e3);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".s2.outs"}, 32'({if2.gray_sync, if2.bin, if2.delta, if2.step, if2.err}), 32'(0));
        check_val({tag, ".s3.outs"}, 32'({if3.gray_sync, if3.bin, if3.delta, if3.step, if3.err}), 32'(0));
    endtask

    initial begin
        rstn    = 1'b0;
        gray_in = 4'b0110;
        err_clr = 1'b0;
        #2;
        check_zero("rst_async");
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_held");

        gray_in = '0;
        rstn    = 1'b1;
        model_reset();
        repeat (6) tick();

        // Full Gray walk including the 15 -> 0 wrap.
        for (int v = 0; v <= 16; v++) begin
            gray_in = W'(v ^ (v >> 1));
            repeat (4) tick();
        end

        gray_in = 4'b0011;
        repeat (12) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (4) tick();

        // Clear held over both instances' arrival edges so each sees set and clear together.
        gray_in = 4'b0101;
        tick();
        tick();
        err_clr = 1'b1;
        tick();
        tick();
        err_clr = 1'b0;
        repeat (4) tick();

        for (int v = 7; v <= 9; v++) begin
            gray_in = W'(v ^ (v >> 1));
            repeat (4) tick();
        end

        #2;
        rstn = 1'b0;
        #1;
        check_zero("mid_async");
        @(posedge clk);
        #1;
        check_zero("mid_held");
        rstn = 1'b1;
        model_reset();
        repeat (8) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
